// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes and FSM states.
package dmem_pkg;

  // MemSize encodings; 2'b11 is treated as a word access.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } mem_size_e;

  // Wait-state handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: extracts and extends load data, merges store
// data into the addressed word, and flags alignment faults (not gated by req).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  mem_size_e   size;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  // Select lane, extend the load value and build the read-modify-write word.
  always_comb begin
    size         = mem_size_e'(size_i);
    shamt        = {lane_i, 3'b000};
    shifted      = word_i >> shamt;
    rdata_o      = '0;
    lane_mask    = '0;
    misaligned_o = 1'b0;
    case (size)
      SZ_BYTE: begin
        rdata_o   = {{24{signed_i & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        rdata_o      = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        lane_mask    = 32'h0000_FFFF << shamt;
        misaligned_o = lane_i[0];
      end
      default: begin
        rdata_o      = word_i;
        lane_mask    = '1;
        misaligned_o = |lane_i;
      end
    endcase
    lane_data = wdata_i << shamt;
    merged_o  = (word_i & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/data_memory_sized.sv
// MEM-stage data memory with byte/half/word access, optional wait states
// signalled through Stall, and misalignment suppression.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] DAddress,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        Stall,
  output logic        Misaligned
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic          align_err;
  logic          req;
  logic          req_ok;
  logic          complete;
  logic          stall_raw;
  logic          unused_addr;

  // Upper address bits alias onto the array.
  assign widx        = DAddress[AW+1:2];
  assign unused_addr = ^DAddress[31:AW+2];
  assign rd_word     = mem_q[widx];
  assign req         = MemRead | MemWrite;
  assign req_ok      = req & ~align_err;

  dmem_lane_align u_align (
    .word_i       (rd_word),
    .lane_i       (DAddress[1:0]),
    .size_i       (MemSize),
    .signed_i     (MemSigned),
    .wdata_i      (Data_in),
    .rdata_o      (ld_data),
    .merged_o     (st_word),
    .misaligned_o (align_err)
  );

  generate
    if (LATENCY == 0) begin : g_comb
      assign stall_raw = 1'b0;
      assign complete  = req_ok;
    end else begin : g_fsm
      localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

      dmem_state_e      state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // State and wait-counter registers.
      always_ff @(posedge clock) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Losing an aligned request in BUSY/DONE is a flush: drop back to IDLE.
      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        complete  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (req_ok) begin
              stall_raw = 1'b1;
              cnt_d     = CNT_INIT;
              state_d   = (LATENCY > 1) ? ST_BUSY : ST_DONE;
            end
          end
          ST_BUSY: begin
            if (req_ok) begin
              stall_raw = 1'b1;
              cnt_d     = cnt_q - 1'b1;
              if (cnt_q == 1) state_d = ST_DONE;
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
          ST_DONE: begin
            complete = req_ok;
            state_d  = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  endgenerate

  assign Stall      = ~reset & stall_raw;
  assign Misaligned = ~reset & req & align_err;
  assign Data_out   = (~reset & complete & MemRead & ~MemWrite) ? ld_data : '0;

  // Array clear on reset; otherwise commit the merged word at the end of the completing cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (complete & MemWrite) begin
      mem_q[widx] <= st_word;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: one single-cycle instance and one LATENCY=3
// instance, each checked every cycle against a byte-array reference model.
module tb_data_memory_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rd0, wr0, sg0, rst1, rd1, wr1, sg1;
  logic [1:0]  sz0, sz1;
  logic [31:0] ad0, di0, ad1, di1;
  logic [31:0] do0, do1;
  logic        st0, ms0, st1, ms1;

  data_memory_sized #(.DEPTH(32), .AW(5), .LATENCY(0)) u0 (
    .clock(clk), .reset(rst0), .MemRead(rd0), .MemWrite(wr0), .MemSize(sz0),
    .MemSigned(sg0), .DAddress(ad0), .Data_in(di0), .Data_out(do0),
    .Stall(st0), .Misaligned(ms0));

  data_memory_sized #(.DEPTH(32), .AW(5), .LATENCY(3)) u1 (
    .clock(clk), .reset(rst1), .MemRead(rd1), .MemWrite(wr1), .MemSize(sz1),
    .MemSigned(sg1), .DAddress(ad1), .Data_in(di1), .Data_out(do1),
    .Stall(st1), .Misaligned(ms1));

  // Reference model: memory as 128 bytes; w1 = stall cycles already served.
  logic [7:0] mb0 [128];
  logic [7:0] mb1 [128];
  int         w1 = 0;
  int         checks = 0;
  int         errors = 0;
  bit         run = 1'b0;

  // Literal expectations set by the stimulus alongside its inputs.
  bit          lit_d0_en = 0, lit_m0_en = 0, lit_d1_en = 0, lit_s1_en = 0;
  logic [31:0] lit_d0 = '0, lit_d1 = '0;
  logic        lit_s1 = 1'b0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mmis(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a);
    return (rd || wr) && ((sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0));
  endfunction

  function automatic logic [31:0] mload(input bit which, input logic [1:0] sz, input logic sg,
                                        input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  b;
    int          n, base;
    n = nbytes(sz);
    base = int'(a % 128);
    v = 0;
    for (int i = 0; i < n; i++) begin
      b = which ? mb1[(base + i) % 128] : mb0[(base + i) % 128];
      v = v + (32'(b) << (8 * i));
    end
    if (sg && n < 4 && v[8*n-1]) v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mb0[i] = '0;
      mb1[i] = '0;
    end
  end

  // Model state advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst0) begin
      for (int i = 0; i < 128; i++) mb0[i] <= '0;
    end else if (wr0 && !mmis(rd0, wr0, sz0, ad0)) begin
      for (int i = 0; i < 4; i++)
        if (i < nbytes(sz0)) mb0[(int'(ad0 % 128) + i) % 128] <= 8'(di0 >> (8 * i));
    end
    if (rst1) begin
      for (int i = 0; i < 128; i++) mb1[i] <= '0;
      w1 <= 0;
    end else if (!(rd1 || wr1) || mmis(rd1, wr1, sz1, ad1)) begin
      w1 <= 0;
    end else if (w1 < 3) begin
      w1 <= w1 + 1;
    end else begin
      w1 <= 0;
      if (wr1)
        for (int i = 0; i < 4; i++)
          if (i < nbytes(sz1)) mb1[(int'(ad1 % 128) + i) % 128] <= 8'(di1 >> (8 * i));
    end
  end

  // Single compare process, sampled mid-cycle.
  always @(negedge clk) begin
    bit          mis, areq, comp;
    logic [31:0] e_out;
    if (run) begin
      mis   = mmis(rd0, wr0, sz0, ad0);
      e_out = (!rst0 && rd0 && !wr0 && !mis) ? mload(0, sz0, sg0, ad0) : 32'h0;
      chk("l0_data", do0, e_out);
      chk("l0_stall", 32'(st0), 32'(0));
      chk("l0_mis", 32'(ms0), 32'(!rst0 && mis));
      if (lit_d0_en) begin
        chk("l0_lit_dut", do0, lit_d0);
        chk("l0_lit_model", e_out, lit_d0);
      end
      if (lit_m0_en) chk("l0_lit_mis", 32'(ms0), 32'(1));

      mis   = mmis(rd1, wr1, sz1, ad1);
      areq  = (rd1 || wr1) && !mis;
      comp  = !rst1 && areq && (w1 == 3);
      e_out = (comp && rd1 && !wr1) ? mload(1, sz1, sg1, ad1) : 32'h0;
      chk("l3_data", do1, e_out);
      chk("l3_stall", 32'(st1), 32'(!rst1 && areq && w1 < 3));
      chk("l3_mis", 32'(ms1), 32'(!rst1 && mis));
      if (lit_d1_en) begin
        chk("l3_lit_dut", do1, lit_d1);
        chk("l3_lit_model", e_out, lit_d1);
      end
      if (lit_s1_en) chk("l3_lit_stall", 32'(st1), 32'(lit_s1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit len, input logic [31:0] lv, input bit mlit);
    rd0 = rd; wr0 = wr; sz0 = sz; sg0 = sg; ad0 = a; di0 = d;
    lit_d0_en = len; lit_d0 = lv; lit_m0_en = mlit;
    cyc();
    lit_d0_en = 0; lit_m0_en = 0;
  endtask

  task automatic set1(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    rd1 = rd; wr1 = wr; sz1 = sz; sg1 = sg; ad1 = a; di1 = d;
  endtask

  // Full held access on the LATENCY=3 instance: 3 stall cycles then completion.
  task automatic op1(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    set1(rd, wr, sz, sg, a, d);
    for (int k = 0; k < 4; k++) begin
      lit_s1_en = 1; lit_s1 = (k < 3);
      lit_d1_en = (k == 3); lit_d1 = exp;
      cyc();
    end
    lit_s1_en = 0; lit_d1_en = 0;
  endtask

  initial begin
    rst0 = 1; rst1 = 1;
    rd0 = 0; wr0 = 0; sz0 = 0; sg0 = 0; ad0 = 0; di0 = 0;
    set1(0, 0, 0, 0, 0, 0);
    run = 1;
    cyc(); cyc();
    rst0 = 0; rst1 = 0;

    // Single-cycle instance: directed sequence.
    op0(0, 1, 2, 0, 32'h8,  32'hDEAD_BEEF, 0, 0, 0);
    op0(1, 0, 0, 1, 32'h9,  0, 1, 32'hFFFF_FFBE, 0);
    op0(1, 0, 0, 0, 32'h9,  0, 1, 32'h0000_00BE, 0);
    op0(1, 0, 1, 1, 32'hA,  0, 1, 32'hFFFF_DEAD, 0);
    op0(0, 1, 1, 0, 32'hA,  32'h0000_1234, 0, 0, 0);
    op0(1, 0, 2, 0, 32'h8,  0, 1, 32'h1234_BEEF, 0);
    op0(0, 1, 0, 0, 32'h8,  32'h0000_0077, 0, 0, 0);
    op0(1, 0, 2, 0, 32'h8,  0, 1, 32'h1234_BE77, 0);
    op0(1, 0, 2, 0, 32'h6,  0, 1, 32'h0, 1);
    op0(0, 1, 1, 0, 32'h9,  32'h0000_FFFF, 0, 0, 1);
    op0(1, 0, 2, 0, 32'h8,  0, 1, 32'h1234_BE77, 0);
    op0(0, 1, 2, 0, 32'h80, 32'hA5A5_A5A5, 0, 0, 0);
    op0(1, 0, 2, 0, 32'h0,  0, 1, 32'hA5A5_A5A5, 0);
    op0(1, 1, 2, 0, 32'h4,  32'h1122_3344, 1, 32'h0, 0);
    op0(1, 0, 2, 0, 32'h4,  0, 1, 32'h1122_3344, 0);

    // Single-cycle instance: random traffic including aliasing and misalignment.
    repeat (300)
      op0(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
          32'($urandom_range(0, 511)), $urandom, 0, 0, 0);
    op0(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // LATENCY=3 instance: back-to-back held accesses.
    op1(0, 1, 2, 0, 32'h8, 32'hDEAD_BEEF, 32'h0);
    op1(1, 0, 2, 0, 32'h8, 0, 32'hDEAD_BEEF);
    op1(0, 1, 0, 0, 32'hB, 32'h0000_0011, 32'h0);
    op1(1, 0, 2, 0, 32'h8, 0, 32'h11AD_BEEF);
    op1(1, 0, 1, 1, 32'hA, 0, 32'h0000_11AD);

    // Misaligned access completes at once with no stall.
    set1(1, 0, 2, 0, 32'h6, 0);
    lit_s1_en = 1; lit_s1 = 0;
    cyc();

    // Store aborted by reset in the second BUSY cycle.
    set1(0, 1, 2, 0, 32'h10, 32'hCAFE_F00D);
    lit_s1 = 1;
    cyc(); cyc();
    rst1 = 1; lit_s1 = 0;
    cyc();
    rst1 = 0;
    set1(0, 0, 0, 0, 0, 0);
    cyc();
    lit_s1_en = 0;
    op1(1, 0, 2, 0, 32'h10, 0, 32'h0);
    op1(1, 0, 2, 0, 32'h8, 0, 32'h0);

    // LATENCY=3 instance: random holds, flushes and back-to-back repeats.
    repeat (80) begin
      if ($urandom_range(0, 3) == 0)
        set1(0, 0, 2'($urandom_range(0, 3)), 0, 32'($urandom_range(0, 255)), $urandom);
      else
        set1(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 255)), $urandom);
      repeat ($urandom_range(1, 6)) cyc();
    end
    set1(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
